ovi_vpu_responder: RTL and testbench

- VPU-side end of the OVI link: a behavioural VPU model that accepts issued vector instructions, honours dispatch and kill, and drives sync-start.
- Sources store data under store credits, sinks load packets, reports completion and returns issue credits.
- Sits opposite the core-side OVI bridge in the simulation top, replacing the real VPU for integration tests.

---
 rtl/ovi_vpu_responder.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_ovi_vpu_responder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovi_vpu_responder.sv
// Behavioural VPU end of the OVI link: queues issued vector instructions,
// follows dispatch/kill, runs a small per-instruction FSM (exec, or
// sync-start plus store/load data phase), reports completion and returns
// issue credits. Flags protocol violations on a sticky PROTO_ERR.
module ovi_vpu_responder #(
  parameter int SBID_W            = 5,
  parameter int VL_W              = 15,
  parameter int DATA_W            = 512,
  parameter int QDEPTH            = 4,
  parameter int EXEC_LAT          = 3,
  parameter int STORE_CREDIT_INIT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ISSUE_VALID,
  input  logic [31:0]       ISSUE_INSTR,
  input  logic [63:0]       ISSUE_SCALAR_OPND,
  input  logic [SBID_W-1:0] ISSUE_SB_ID,
  input  logic [VL_W-1:0]   ISSUE_VL,
  input  logic [1:0]        ISSUE_VSEW,
  output logic              ISSUE_CREDIT,
  input  logic              DISPATCH_NEXT_SENIOR,
  input  logic              DISPATCH_KILL,
  output logic              COMPLETED_VALID,
  output logic [SBID_W-1:0] COMPLETED_SB_ID,
  output logic [63:0]       COMPLETED_DEST_REG,
  output logic              SYNC_START,
  input  logic              MEMOP_SYNC_END,
  input  logic [SBID_W-1:0] MEMOP_SB_ID,
  output logic              STORE_VALID,
  output logic [DATA_W-1:0] STORE_DATA,
  input  logic              STORE_CREDIT,
  input  logic              LOAD_VALID,
  input  logic [DATA_W-1:0] LOAD_DATA,
  input  logic [10:0]       LOAD_EL_ID,
  output logic              PROTO_ERR
);

  localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW    = $clog2(QDEPTH + 1);
  localparam int LANES = DATA_W / 32;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_SYNC, S_STORE_TX, S_LOAD_RX, S_WAIT_END, S_DONE
  } state_t;

  state_t state, next;

  // instruction queue
  logic [31:0]       q_instr [QDEPTH];
  logic [63:0]       q_opnd  [QDEPTH];
  logic [SBID_W-1:0] q_sb    [QDEPTH];
  logic [VL_W-1:0]   q_vl    [QDEPTH];
  logic [1:0]        q_vsew  [QDEPTH];
  logic [QDEPTH-1:0] q_disp, q_kill;
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;

  logic q_full, push, pop, dsp_any, d_found;
  logic [PW-1:0] d_idx;

  // head view and derived packet geometry
  logic [31:0]       h_instr;
  logic [63:0]       h_opnd;
  logic [SBID_W-1:0] h_sb;
  logic [1:0]        h_vsew;
  logic [VL_W-1:0]   h_vl;
  logic              is_load, is_store, is_mem;
  logic [2:0]        sh;
  logic [31:0]       bits, np, epp;

  // data-phase state
  logic [31:0]       ecnt, sent, rcv, el_exp;
  logic [63:0]       acc;
  logic [4:0]        st_cred;
  logic              end_lat;
  logic [SBID_W-1:0] lat_id;
  logic              proto_q;

  // FSM outputs before reset gating
  logic credit_c, cmpl_c, sync_c, send;
  logic [63:0] dest_c;
  logic err_push, err_disp, err_end, err_sb, err_el, err_cred, end_ok;

  assign q_full  = (count == CW'(QDEPTH));
  assign push    = ISSUE_VALID && !q_full;
  assign dsp_any = DISPATCH_NEXT_SENIOR || DISPATCH_KILL;

  assign h_instr  = q_instr[head];
  assign h_opnd   = q_opnd[head];
  assign h_sb     = q_sb[head];
  assign h_vl     = q_vl[head];
  assign h_vsew   = q_vsew[head];
  assign is_load  = (h_instr[6:0] == 7'b0000111);
  assign is_store = (h_instr[6:0] == 7'b0100111);
  assign is_mem   = is_load || is_store;

  // element width in bits is 8 << vsew, so shift by vsew+3
  assign sh   = {1'b0, h_vsew} + 3'd3;
  assign bits = {{(32-VL_W){1'b0}}, h_vl} << sh;
  assign np   = (bits + 32'(DATA_W - 1)) / 32'(DATA_W);
  assign epp  = 32'(DATA_W) >> sh;

  assign send = (state == S_STORE_TX) && (sent < np) && (st_cred != 5'd0);

  // find the oldest entry not yet dispatched or killed
  always_comb begin
    d_found = 1'b0;
    d_idx   = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      int k;
      k = (int'(head) + i) % QDEPTH;
      if (!d_found && i < int'(count) && !q_disp[k] && !q_kill[k]) begin
        d_found = 1'b1;
        d_idx   = PW'(k);
      end
    end
  end

  // queue payload write (no reset needed, validity tracked by count)
  always_ff @(posedge CLK) begin
    if (push) begin
      q_instr[tail] <= ISSUE_INSTR;
      q_opnd[tail]  <= ISSUE_SCALAR_OPND;
      q_sb[tail]    <= ISSUE_SB_ID;
      q_vl[tail]    <= ISSUE_VL;
      q_vsew[tail]  <= ISSUE_VSEW;
    end
  end

  // queue pointers, occupancy and dispatch/kill flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      q_disp <= '0;
      q_kill <= '0;
    end else begin
      if (push) begin
        tail         <= (tail == PW'(QDEPTH - 1)) ? '0 : tail + PW'(1);
        q_disp[tail] <= 1'b0;
        q_kill[tail] <= 1'b0;
      end
      if (pop)
        head <= (head == PW'(QDEPTH - 1)) ? '0 : head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      // kill wins when both dispatch strobes arrive together
      if (dsp_any && d_found) begin
        if (DISPATCH_KILL) q_kill[d_idx] <= 1'b1;
        else               q_disp[d_idx] <= 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= next;
  end

  // next state and per-cycle strobes
  always_comb begin
    next     = state;
    pop      = 1'b0;
    credit_c = 1'b0;
    cmpl_c   = 1'b0;
    sync_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          if (q_kill[head]) begin
            pop      = 1'b1;
            credit_c = 1'b1;
          end else if (q_disp[head]) begin
            next = is_mem ? S_SYNC : S_EXEC;
          end
        end
      end
      S_EXEC:     if (ecnt + 32'd1 >= 32'(EXEC_LAT)) next = S_DONE;
      S_SYNC: begin
        sync_c = 1'b1;
        if (np == 32'd0)   next = S_WAIT_END;
        else if (is_store) next = S_STORE_TX;
        else               next = S_LOAD_RX;
      end
      S_STORE_TX: if (sent == np) next = S_WAIT_END;
      S_LOAD_RX:  if (rcv == np)  next = S_WAIT_END;
      S_WAIT_END: if (MEMOP_SYNC_END || end_lat) next = S_DONE;
      S_DONE: begin
        cmpl_c   = 1'b1;
        credit_c = 1'b1;
        pop      = 1'b1;
        next     = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  // exec timer, data-phase counters, load accumulator, early sync-end latch
  always_ff @(posedge CLK) begin
    if (RST) begin
      ecnt    <= '0;
      sent    <= '0;
      rcv     <= '0;
      el_exp  <= '0;
      acc     <= '0;
      end_lat <= 1'b0;
      lat_id  <= '0;
    end else begin
      ecnt <= (state == S_EXEC) ? ecnt + 32'd1 : 32'd0;
      if (state == S_SYNC) begin
        sent    <= '0;
        rcv     <= '0;
        el_exp  <= '0;
        acc     <= '0;
        end_lat <= 1'b0;
      end
      if (send) sent <= sent + 32'd1;
      if (state == S_LOAD_RX && LOAD_VALID) begin
        rcv    <= rcv + 32'd1;
        el_exp <= el_exp + epp;
        acc    <= acc + LOAD_DATA[63:0];
      end
      if (MEMOP_SYNC_END && (state == S_STORE_TX || state == S_LOAD_RX)) begin
        end_lat <= 1'b1;
        lat_id  <= MEMOP_SB_ID;
      end
      if (state == S_DONE) end_lat <= 1'b0;
    end
  end

  // store credit counter, saturating at 31
  always_ff @(posedge CLK) begin
    if (RST)
      st_cred <= 5'(STORE_CREDIT_INIT);
    else if (STORE_CREDIT && !send && st_cred != 5'd31)
      st_cred <= st_cred + 5'd1;
    else if (!STORE_CREDIT && send)
      st_cred <= st_cred - 5'd1;
  end

  assign end_ok   = (state == S_WAIT_END) || (state == S_STORE_TX) || (state == S_LOAD_RX);
  assign err_push = ISSUE_VALID && q_full;
  assign err_disp = dsp_any && !d_found;
  assign err_end  = MEMOP_SYNC_END && !end_ok;
  assign err_sb   = (state == S_WAIT_END) && (MEMOP_SYNC_END || end_lat) &&
                    ((end_lat ? lat_id : MEMOP_SB_ID) != h_sb);
  assign err_el   = (state == S_LOAD_RX) && LOAD_VALID && ({21'b0, LOAD_EL_ID} != el_exp);
  assign err_cred = STORE_CREDIT && !send && (st_cred == 5'd31);

  // sticky protocol error
  always_ff @(posedge CLK) begin
    if (RST) proto_q <= 1'b0;
    else if (err_push || err_disp || err_end || err_sb || err_el || err_cred)
      proto_q <= 1'b1;
  end

  // scalar result chosen by instruction class
  always_comb begin
    dest_c = '0;
    if (cmpl_c) begin
      if (is_load)       dest_c = acc;
      else if (is_store) dest_c = {32'b0, np};
      else               dest_c = h_opnd + 64'd1;
    end
  end

  // outputs held at zero while reset is asserted
  assign ISSUE_CREDIT       = !RST && credit_c;
  assign COMPLETED_VALID    = !RST && cmpl_c;
  assign COMPLETED_SB_ID    = (!RST && cmpl_c) ? h_sb : '0;
  assign COMPLETED_DEST_REG = RST ? 64'd0 : dest_c;
  assign SYNC_START         = !RST && sync_c;
  assign STORE_VALID        = !RST && send;
  assign PROTO_ERR          = !RST && proto_q;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign STORE_DATA[j*32 +: 32] = (!RST && send) ?
      {8'hA5, 8'(h_sb), sent[7:0], 8'(j)} : 32'd0;
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, h_instr[31:7], LOAD_DATA[DATA_W-1:64]};

endmodule

// File: tb/tb_ovi_vpu_responder.sv
// Scoreboard bench for ovi_vpu_responder: completions and store packets are
// queued as expectations when stimulus is driven and checked by a monitor.
module tb_ovi_vpu_responder;

  localparam int SBID_W = 5, VL_W = 15, DATA_W = 512, EXEC_LAT = 3;
  localparam logic [31:0] OP_ARITH = 32'h0000_0057;
  localparam logic [31:0] OP_LOAD  = 32'h0000_0007;
  localparam logic [31:0] OP_STORE = 32'h0000_0027;

  logic CLK = 1'b0, RST = 1'b1;
  logic ISSUE_VALID = 0, DISPATCH_NEXT_SENIOR = 0, DISPATCH_KILL = 0;
  logic [31:0] ISSUE_INSTR = '0;
  logic [63:0] ISSUE_SCALAR_OPND = '0;
  logic [SBID_W-1:0] ISSUE_SB_ID = '0, MEMOP_SB_ID = '0;
  logic [VL_W-1:0] ISSUE_VL = '0;
  logic [1:0] ISSUE_VSEW = '0;
  logic MEMOP_SYNC_END = 0, STORE_CREDIT = 0, LOAD_VALID = 0;
  logic [DATA_W-1:0] LOAD_DATA = '0;
  logic [10:0] LOAD_EL_ID = '0;
  logic ISSUE_CREDIT, COMPLETED_VALID, SYNC_START, STORE_VALID, PROTO_ERR;
  logic [SBID_W-1:0] COMPLETED_SB_ID;
  logic [63:0] COMPLETED_DEST_REG;
  logic [DATA_W-1:0] STORE_DATA;

  ovi_vpu_responder dut (
    .CLK(CLK), .RST(RST),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_INSTR(ISSUE_INSTR),
    .ISSUE_SCALAR_OPND(ISSUE_SCALAR_OPND), .ISSUE_SB_ID(ISSUE_SB_ID),
    .ISSUE_VL(ISSUE_VL), .ISSUE_VSEW(ISSUE_VSEW), .ISSUE_CREDIT(ISSUE_CREDIT),
    .DISPATCH_NEXT_SENIOR(DISPATCH_NEXT_SENIOR), .DISPATCH_KILL(DISPATCH_KILL),
    .COMPLETED_VALID(COMPLETED_VALID), .COMPLETED_SB_ID(COMPLETED_SB_ID),
    .COMPLETED_DEST_REG(COMPLETED_DEST_REG), .SYNC_START(SYNC_START),
    .MEMOP_SYNC_END(MEMOP_SYNC_END), .MEMOP_SB_ID(MEMOP_SB_ID),
    .STORE_VALID(STORE_VALID), .STORE_DATA(STORE_DATA), .STORE_CREDIT(STORE_CREDIT),
    .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA), .LOAD_EL_ID(LOAD_EL_ID),
    .PROTO_ERR(PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [SBID_W-1:0] sb; logic [63:0] dest; } cmpl_t;
  cmpl_t exp_q[$];
  logic [DATA_W-1:0] pkt_q[$];
  cmpl_t m_e;
  logic [DATA_W-1:0] m_p;
  int n_chk = 0, n_fail = 0, n_cmpl = 0, n_credit = 0, n_sync = 0;

  // monitor: compare every completion and store packet against the queues
  always @(negedge CLK) begin
    if (!RST) begin
      if (COMPLETED_VALID) begin
        n_cmpl++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL cmpl_unexpected got sb=%0d dest=%0d, none expected", COMPLETED_SB_ID, COMPLETED_DEST_REG);
        end else begin
          m_e = exp_q.pop_front();
          if (COMPLETED_SB_ID !== m_e.sb || COMPLETED_DEST_REG !== m_e.dest) begin
            n_fail++;
            $display("FAIL cmpl got sb=%0d dest=%0d want sb=%0d dest=%0d", COMPLETED_SB_ID, COMPLETED_DEST_REG, m_e.sb, m_e.dest);
          end
        end
      end
      if (STORE_VALID) begin
        n_chk++;
        if (pkt_q.size() == 0) begin
          n_fail++;
          $display("FAIL store_unexpected got lane0=%h", STORE_DATA[31:0]);
        end else begin
          m_p = pkt_q.pop_front();
          if (STORE_DATA !== m_p) begin
            n_fail++;
            $display("FAIL store_pkt got lane0=%h lane15=%h want lane0=%h lane15=%h", STORE_DATA[31:0], STORE_DATA[511:480], m_p[31:0], m_p[511:480]);
          end
        end
      end
      if (ISSUE_CREDIT) n_credit++;
      if (SYNC_START) n_sync++;
    end
  end

  function automatic logic [DATA_W-1:0] mk_pkt(input logic [SBID_W-1:0] sb, input int p);
    logic [DATA_W-1:0] r;
    for (int j = 0; j < DATA_W/32; j++) r[j*32 +: 32] = {8'hA5, 3'b000, sb, p[7:0], j[7:0]};
    return r;
  endfunction

  task tick; @(posedge CLK); #1; endtask

  task clr_in;
    ISSUE_VALID = 0; DISPATCH_NEXT_SENIOR = 0; DISPATCH_KILL = 0;
    MEMOP_SYNC_END = 0; STORE_CREDIT = 0; LOAD_VALID = 0; LOAD_DATA = '0; LOAD_EL_ID = '0;
  endtask

  task do_reset;
    RST = 1; clr_in(); tick(); tick();
    exp_q.delete(); pkt_q.delete();
    RST = 0; tick();
  endtask

  task automatic issue(input logic [31:0] ins, input logic [63:0] op, input logic [SBID_W-1:0] sb,
                       input logic [VL_W-1:0] vl, input logic [1:0] vsew);
    ISSUE_VALID = 1; ISSUE_INSTR = ins; ISSUE_SCALAR_OPND = op;
    ISSUE_SB_ID = sb; ISSUE_VL = vl; ISSUE_VSEW = vsew;
    tick(); ISSUE_VALID = 0;
  endtask

  task automatic dispatch(input bit kill);
    if (kill) DISPATCH_KILL = 1; else DISPATCH_NEXT_SENIOR = 1;
    tick(); DISPATCH_KILL = 0; DISPATCH_NEXT_SENIOR = 0;
  endtask

  task automatic sync_end(input logic [SBID_W-1:0] sb);
    MEMOP_SYNC_END = 1; MEMOP_SB_ID = sb; tick(); MEMOP_SYNC_END = 0;
  endtask

  task automatic wait_cmpl(input int target, input string tag);
    int n = 0;
    while (n_cmpl < target && n < 60) begin tick(); n++; end
    n_chk++;
    if (n_cmpl < target) begin
      n_fail++;
      $display("FAIL %s_timeout completions got %0d want %0d", tag, n_cmpl, target);
    end
  endtask

  task test_reset;
    RST = 1; clr_in(); tick(); tick();
    n_chk++;
    if ({ISSUE_CREDIT, COMPLETED_VALID, SYNC_START, STORE_VALID, PROTO_ERR, COMPLETED_SB_ID} !== '0 ||
        COMPLETED_DEST_REG !== '0 || STORE_DATA !== '0) begin
      n_fail++; $display("FAIL reset_outputs got nonzero output during reset, want all 0");
    end
    RST = 0; tick();
    n_chk++;
    if ({ISSUE_CREDIT, COMPLETED_VALID, SYNC_START, STORE_VALID, PROTO_ERR} !== 5'b0) begin
      n_fail++; $display("FAIL idle_outputs got %b want 00000", {ISSUE_CREDIT, COMPLETED_VALID, SYNC_START, STORE_VALID, PROTO_ERR});
    end
  endtask

  task automatic test_arith;
    int n = 0;
    exp_q.push_back('{sb: 5'd3, dest: 64'd42});
    issue(OP_ARITH, 64'd41, 5'd3, 15'd8, 2'd0);
    dispatch(0);
    while (!COMPLETED_VALID && n < 20) begin tick(); n++; end
    n_chk++;
    if (n !== EXEC_LAT + 1) begin n_fail++; $display("FAIL arith_latency got %0d want %0d", n, EXEC_LAT + 1); end
    n_chk++;
    if (ISSUE_CREDIT !== 1'b1) begin n_fail++; $display("FAIL arith_credit got %b want 1", ISSUE_CREDIT); end
    tick();
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL arith_pending got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_store;
    int ret[$];
    int pk = 0, c0, s0;
    logic [DATA_W-1:0] p1;
    p1 = '0;
    c0 = n_cmpl; s0 = n_sync;
    pkt_q.push_back(mk_pkt(5'd6, 0));
    pkt_q.push_back(mk_pkt(5'd6, 1));
    exp_q.push_back('{sb: 5'd6, dest: 64'd2});
    issue(OP_STORE, 64'd0, 5'd6, 15'd32, 2'd2);
    dispatch(0);
    for (int c = 0; c < 60 && !(pk == 2 && ret.size() == 0); c++) begin
      STORE_CREDIT = 0;
      if (ret.size() > 0 && ret[0] == c) begin STORE_CREDIT = 1; void'(ret.pop_front()); end
      if (STORE_VALID) begin
        if (pk == 1) p1 = STORE_DATA;
        pk++;
        ret.push_back(c + 2);
      end
      tick();
    end
    STORE_CREDIT = 0;
    n_chk++;
    if (pk !== 2) begin n_fail++; $display("FAIL store_pkts got %0d want 2", pk); end
    n_chk++;
    if (p1[127:96] !== 32'hA506_0103) begin n_fail++; $display("FAIL store_p1_lane3 got %h want a5060103", p1[127:96]); end
    n_chk++;
    if (n_cmpl !== c0) begin n_fail++; $display("FAIL store_early_cmpl got %0d want %0d", n_cmpl, c0); end
    sync_end(5'd6);
    wait_cmpl(c0 + 1, "store");
    n_chk++;
    if (n_sync - s0 !== 1) begin n_fail++; $display("FAIL store_sync got %0d want 1", n_sync - s0); end
    n_chk++;
    if (PROTO_ERR !== 1'b0) begin n_fail++; $display("FAIL store_proto got %b want 0", PROTO_ERR); end
  endtask

  task automatic test_load(input logic [SBID_W-1:0] sb, input logic [10:0] el2, input logic err_exp, input string tag);
    int n = 0, c0;
    c0 = n_cmpl;
    exp_q.push_back('{sb: sb, dest: 64'd9});
    issue(OP_LOAD, 64'd0, sb, 15'd20, 2'd3);
    dispatch(0);
    while (!SYNC_START && n < 20) begin tick(); n++; end
    n_chk++;
    if (SYNC_START !== 1'b1) begin n_fail++; $display("FAIL %s_sync_timeout got 0 want 1", tag); end
    tick();
    for (int k = 0; k < 3; k++) begin
      LOAD_VALID = 1; LOAD_DATA = '0; LOAD_DATA[63:0] = 64'd3;
      LOAD_EL_ID = (k == 2) ? el2 : 11'(k * 8);
      tick();
    end
    LOAD_VALID = 0; LOAD_DATA = '0;
    tick();
    sync_end(sb);
    wait_cmpl(c0 + 1, tag);
    n_chk++;
    if (PROTO_ERR !== err_exp) begin n_fail++; $display("FAIL %s_proto got %b want %b", tag, PROTO_ERR, err_exp); end
  endtask

  task automatic test_queue_full;
    int c0, cr0;
    do_reset();
    c0 = n_cmpl; cr0 = n_credit;
    exp_q.push_back('{sb: 5'd11, dest: 64'd101});
    exp_q.push_back('{sb: 5'd13, dest: 64'd103});
    exp_q.push_back('{sb: 5'd14, dest: 64'd104});
    for (int i = 0; i < 4; i++) issue(OP_ARITH, 64'(100 + i), 5'(11 + i), 15'd1, 2'd0);
    n_chk++;
    if (PROTO_ERR !== 1'b0) begin n_fail++; $display("FAIL qfull_before got %b want 0", PROTO_ERR); end
    issue(OP_ARITH, 64'd200, 5'd15, 15'd1, 2'd0);
    n_chk++;
    if (PROTO_ERR !== 1'b1) begin n_fail++; $display("FAIL qfull_drop got %b want 1", PROTO_ERR); end
    dispatch(0); dispatch(1); dispatch(0); dispatch(0);
    wait_cmpl(c0 + 3, "qfull");
    repeat (20) tick();
    n_chk++;
    if (n_cmpl - c0 !== 3) begin n_fail++; $display("FAIL qfull_cmpls got %0d want 3", n_cmpl - c0); end
    n_chk++;
    if (n_credit - cr0 !== 4) begin n_fail++; $display("FAIL qfull_credits got %0d want 4", n_credit - cr0); end
  endtask

  task automatic test_reset_mid;
    int n = 0, c0, cr0;
    do_reset();
    c0 = n_cmpl; cr0 = n_credit;
    pkt_q.push_back(mk_pkt(5'd7, 0));
    issue(OP_STORE, 64'd0, 5'd7, 15'd32, 2'd2);
    dispatch(0);
    while (!STORE_VALID && n < 20) begin tick(); n++; end
    tick(); tick();
    n_chk++;
    if (STORE_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_stall got %b want 0", STORE_VALID); end
    RST = 1; tick();
    n_chk++;
    if ({ISSUE_CREDIT, COMPLETED_VALID, SYNC_START, STORE_VALID, PROTO_ERR} !== 5'b0 || STORE_DATA !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs got nonzero output want all 0");
    end
    RST = 0; exp_q.delete(); pkt_q.delete();
    tick();
    n_chk++;
    if ({ISSUE_CREDIT, COMPLETED_VALID, SYNC_START, STORE_VALID} !== 4'b0 || n_cmpl !== c0 || n_credit !== cr0) begin
      n_fail++; $display("FAIL mid_abandon got cmpl=%0d credit=%0d want %0d %0d", n_cmpl, n_credit, c0, cr0);
    end
    pkt_q.push_back(mk_pkt(5'd8, 0));
    exp_q.push_back('{sb: 5'd8, dest: 64'd1});
    issue(OP_STORE, 64'd0, 5'd8, 15'd16, 2'd2);
    dispatch(0);
    n = 0;
    while (!STORE_VALID && n < 20) begin tick(); n++; end
    n_chk++;
    if (STORE_VALID !== 1'b1) begin n_fail++; $display("FAIL mid_credit_restore got 0 want 1"); end
    tick();
    sync_end(5'd8);
    wait_cmpl(c0 + 1, "mid_fresh");
    n_chk++;
    if (PROTO_ERR !== 1'b0) begin n_fail++; $display("FAIL mid_proto got %b want 0", PROTO_ERR); end
  endtask

  task automatic test_vl0;
    int c0, s0;
    c0 = n_cmpl; s0 = n_sync;
    exp_q.push_back('{sb: 5'd4, dest: 64'd0});
    issue(OP_LOAD, 64'd0, 5'd4, 15'd0, 2'd0);
    dispatch(0);
    repeat (10) tick();
    n_chk++;
    if (n_sync - s0 !== 1) begin n_fail++; $display("FAIL vl0_sync got %0d want 1", n_sync - s0); end
    n_chk++;
    if (n_cmpl !== c0) begin n_fail++; $display("FAIL vl0_early_cmpl got %0d want %0d", n_cmpl, c0); end
    sync_end(5'd4);
    wait_cmpl(c0 + 1, "vl0");
    n_chk++;
    if (PROTO_ERR !== 1'b0) begin n_fail++; $display("FAIL vl0_proto got %b want 0", PROTO_ERR); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_store();
    test_load(5'd9, 11'd16, 1'b0, "load_ok");
    test_load(5'd10, 11'd17, 1'b1, "load_badel");
    test_queue_full();
    test_reset_mid();
    test_vl0();
    tick();
    n_chk++;
    if (exp_q.size() != 0 || pkt_q.size() != 0) begin
      n_fail++; $display("FAIL leftover got cmpl=%0d pkt=%0d want 0 0", exp_q.size(), pkt_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
